pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Registered program-counter generator for the MIPS core; successor to the combinational next-PC logic.
//   Holds the PC and selects the next PC from sequential, beq/bne, j, jal, jr or return, plus exception and eret.
//   A parametrised return-address stack (RAS) serves function returns.
//   Sits at the front of fetch; its pc output drives the instruction memory address.
// PARAMETERS
//   WIDTH      32            PC width; legal range 32..64.
//   RESET_PC   32'h0000_3000 PC value loaded on reset, zero-extended to WIDTH.
//   EXC_VECTOR 32'h0000_4180 exception entry address, zero-extended to WIDTH.
//   RAS_DEPTH  4             return-address stack entries; must be >= 2.
// PORTS
//   clk        in  1      clock; all state changes on the rising edge.
//   rst        in  1      synchronous reset, active-high.
//   stall      in  1      hold the PC and the RAS this cycle.
//   pc_sel     in  3      000 seq, 001 branch, 010 j, 011 jal, 100 jr, 101 ret; 110/111 behave as seq.
//   br_imm     in  16     branch offset, in words.
//   br_taken   in  1      branch condition result; used only when pc_sel=001.
//   j_index    in  26     jump instruction index field.
//   jr_target  in  WIDTH  register-file jump target.
//   exc_req    in  1      take exception.
//   eret       in  1      return from exception.
//   epc        in  WIDTH  exception return address.
//   pc         out WIDTH  current PC, registered.
//   pc_plus4   out WIDTH  pc+4, combinational, wraps modulo 2^WIDTH.
//   ras_count  out $clog2(RAS_DEPTH+1)  number of valid RAS entries, registered.
//   ras_ovf    out 1      one-cycle pulse, registered: a jal push overwrote the oldest entry.
//   pc_misalign out 1     combinational: pc[1:0] != 0. Flag only; the PC is not corrected.
// BEHAVIOUR
//   Reset: pc=RESET_PC, ras_count=0, ras_ovf=0, RAS pointer=0. Entry contents are don't-care.
//   Update priority per edge: rst > exc_req > eret > stall > pc_sel.
//   exc_req: pc<=EXC_VECTOR; RAS unchanged; eret and stall ignored.
//   eret: pc<=epc; RAS unchanged.
//   stall (no rst/exc/eret): pc, RAS and ras_count hold; ras_ovf<=0.
//   Next-PC by pc_sel:
//     seq:    pc_plus4.
//     branch: br_taken ? pc_plus4 + (sext(br_imm)<<2) : pc_plus4. Arithmetic modulo 2^WIDTH.
//     j:      {pc_plus4[WIDTH-1:28], j_index, 2'b00}.
//     jal:    same target as j; push pc_plus4 onto the RAS.
//     jr:     jr_target; RAS untouched.
//     ret:    ras_count>0 ? top entry (pop) : jr_target (no pop, no error).
//   RAS is circular:
//     - Push when ras_count==RAS_DEPTH overwrites the oldest entry; ras_count stays at RAS_DEPTH; ras_ovf<=1 next cycle.
//     - Otherwise ras_ovf<=0 every cycle.
//   Latency: a new PC is visible on pc exactly one cycle after the selecting inputs; there is no bypass.
//   All inputs are sampled only at the rising edge; the block has no combinational path from inputs to pc.
//   Reset asserted mid-sequence (e.g. during a stall or an exception) overrides everything on that edge.
// TESTING
//   rst 1 cycle, then 3 cycles seq, stall=0 -> pc 3000, 3004, 3008, 300C.
//   pc=3010, branch, br_imm=16'hFFFC, br_taken=1 -> pc=3004; same with br_taken=0 -> pc=3014.
//   pc=3000, jal, j_index=26'h0000100 -> pc=0000_0400, ras_count=1.
//     Then ret -> pc=3004, ras_count=0.
//     Then ret with ras_count=0, jr_target=3100 -> pc=3100.
//   RAS_DEPTH=4: 5 jal pushes -> ras_ovf pulses once after the 5th, ras_count=4;
//     4 rets return the last four pushed addresses newest-first.
//   stall=1 with exc_req=1 -> pc=4180; then eret, epc=3020 -> pc=3020.
//     rst with stall=1 -> pc=3000.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator with a circular return-address stack for the MIPS fetch front end.
// Latency: the PC selected by the inputs appears on pc one cycle later, with no bypass path.
// Backpressure: stall holds pc, the RAS and ras_count and clears ras_ovf. There is no valid/ready handshake.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   stall           hold PC and RAS this cycle
//   pc_sel          000 seq, 001 branch, 010 j, 011 jal, 100 jr, 101 ret (110/111 = seq)
//   br_imm/br_taken branch word offset and condition
//   j_index         jump instruction index field
//   jr_target       register jump target, also the fallback for ret on an empty RAS
//   exc_req/eret/epc exception entry, exception return and its address
//   pc, pc_plus4    current PC (registered) and PC+4 (combinational)
//   ras_count       valid RAS entries
//   ras_ovf         one-cycle pulse after a jal overwrote the oldest entry
//   pc_misalign     PC is not word aligned (flag only)
module pc_gen #(
   parameter int          WIDTH      = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
   parameter int          RAS_DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic [2:0]                     pc_sel,
   input  logic [15:0]                    br_imm,
   input  logic                           br_taken,
   input  logic [25:0]                    j_index,
   input  logic [WIDTH-1:0]               jr_target,
   input  logic                           exc_req,
   input  logic                           eret,
   input  logic [WIDTH-1:0]               epc,
   output logic [WIDTH-1:0]               pc,
   output logic [WIDTH-1:0]               pc_plus4,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_ovf,
   output logic                           pc_misalign
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int PW = $clog2(RAS_DEPTH);

   localparam logic [WIDTH-1:0] RESET_PC_W   = WIDTH'(RESET_PC);
   localparam logic [WIDTH-1:0] EXC_VECTOR_W = WIDTH'(EXC_VECTOR);

   localparam logic [2:0] SEL_SEQ = 3'b000;
   localparam logic [2:0] SEL_BR  = 3'b001;
   localparam logic [2:0] SEL_J   = 3'b010;
   localparam logic [2:0] SEL_JAL = 3'b011;
   localparam logic [2:0] SEL_JR  = 3'b100;
   localparam logic [2:0] SEL_RET = 3'b101;

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   // ras_ptr is the next slot to write. The top of stack is the slot just below it.
   // When the stack is full, ras_ptr also points at the oldest entry, so a push overwrites it.
   logic [PW-1:0]    ras_ptr;
   logic [PW-1:0]    ptr_inc;
   logic [PW-1:0]    ptr_dec;
   logic             ras_full;
   logic             ras_push;
   logic [WIDTH-1:0] br_off;
   logic [WIDTH-1:0] j_target;

   assign pc_plus4    = pc + WIDTH'(4);
   assign pc_misalign = |pc[1:0];

   // Sign-extended word offset, scaled to bytes.
   assign br_off   = {{(WIDTH-18){br_imm[15]}}, br_imm, 2'b00};
   assign j_target = {pc_plus4[WIDTH-1:28], j_index, 2'b00};

   // Explicit wrap so that depths which are not a power of two stay inside the array.
   assign ptr_inc  = (ras_ptr == PW'(RAS_DEPTH-1)) ? '0 : ras_ptr + PW'(1);
   assign ptr_dec  = (ras_ptr == '0) ? PW'(RAS_DEPTH-1) : ras_ptr - PW'(1);
   assign ras_full = (ras_count == CW'(RAS_DEPTH));

   assign ras_push = !rst && !exc_req && !eret && !stall && (pc_sel == SEL_JAL);

   // Entry storage carries no reset. Only the pointer and the count define validity.
   always_ff @(posedge clk) begin
      if (ras_push) begin
         ras_mem[ras_ptr] <= pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC_W;
         ras_count <= '0;
         ras_ovf   <= 1'b0;
         ras_ptr   <= '0;
      end else begin
         ras_ovf <= 1'b0;
         if (exc_req) begin
            pc <= EXC_VECTOR_W;
         end else if (eret) begin
            pc <= epc;
         end else if (!stall) begin
            case (pc_sel)
               SEL_SEQ: pc <= pc_plus4;
               SEL_BR:  pc <= br_taken ? (pc_plus4 + br_off) : pc_plus4;
               SEL_J:   pc <= j_target;
               SEL_JAL: begin
                  pc      <= j_target;
                  ras_ptr <= ptr_inc;
                  if (ras_full) begin
                     ras_ovf <= 1'b1;
                  end else begin
                     ras_count <= ras_count + CW'(1);
                  end
               end
               SEL_JR:  pc <= jr_target;
               SEL_RET: begin
                  // An empty stack falls back to the register target. There is no pop and no error.
                  if (ras_count != '0) begin
                     pc        <= ras_mem[ptr_dec];
                     ras_ptr   <= ptr_dec;
                     ras_count <= ras_count - CW'(1);
                  end else begin
                     pc <= jr_target;
                  end
               end
               default: pc <= pc_plus4;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, stall, br_taken, exc_req, eret;
   logic [2:0]  pc_sel;
   logic [15:0] br_imm;
   logic [25:0] j_index;
   logic [31:0] jr_target, epc;
   logic [31:0] pc, pc_plus4;
   logic [2:0]  ras_count;
   logic        ras_ovf, pc_misalign;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic        m_ovf;
   logic [31:0] ras_q[$];

   always #5 clk = ~clk;

   pc_gen #(.WIDTH(32), .RESET_PC(32'h3000), .EXC_VECTOR(32'h4180), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .br_imm(br_imm),
      .br_taken(br_taken), .j_index(j_index), .jr_target(jr_target),
      .exc_req(exc_req), .eret(eret), .epc(epc), .pc(pc), .pc_plus4(pc_plus4),
      .ras_count(ras_count), .ras_ovf(ras_ovf), .pc_misalign(pc_misalign)
   );

   task automatic idle_inputs();
      rst = 0; stall = 0; pc_sel = 3'b000; br_imm = 0; br_taken = 0;
      j_index = 0; jr_target = 0; exc_req = 0; eret = 0; epc = 0;
   endtask

   // Apply the architectural rules to the model, then let the DUT take the same edge.
   task automatic tick();
      logic [31:0] nxt;
      logic signed [31:0] off;
      nxt   = m_pc + 32'd4;
      off   = 32'($signed(br_imm));
      m_ovf = 1'b0;
      if (rst) begin
         m_pc = 32'h3000;
         ras_q.delete();
      end else if (exc_req) begin
         m_pc = 32'h4180;
      end else if (eret) begin
         m_pc = epc;
      end else if (!stall) begin
         case (pc_sel)
            3'd1: m_pc = br_taken ? nxt + 32'(off * 4) : nxt;
            3'd2: m_pc = {nxt[31:28], j_index, 2'b00};
            3'd3: begin
               if (ras_q.size() == DEPTH) begin
                  void'(ras_q.pop_front());
                  m_ovf = 1'b1;
               end
               ras_q.push_back(nxt);
               m_pc = {nxt[31:28], j_index, 2'b00};
            end
            3'd4: m_pc = jr_target;
            3'd5: m_pc = (ras_q.size() > 0) ? ras_q.pop_back() : jr_target;
            default: m_pc = nxt;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      tests_run++;
      if (pc !== 32'h3000) begin tests_failed++; $display("FAIL reset_pc got %h want 3000", pc); end
      tests_run++;
      if (ras_count !== 3'd0) begin tests_failed++; $display("FAIL reset_ras_count got %0d want 0", ras_count); end
      tests_run++;
      if (ras_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ras_ovf got %b want 0", ras_ovf); end
      tests_run++;
      if (pc_plus4 !== 32'h3004) begin tests_failed++; $display("FAIL reset_pc_plus4 got %h want 3004", pc_plus4); end
      tests_run++;
      if (pc_misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got %b want 0", pc_misalign); end
   endtask

   task automatic test_seq();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (pc !== exp_pc[i]) begin tests_failed++; $display("FAIL seq_%0d got %h want %h", i, pc, exp_pc[i]); end
      end
   endtask

   task automatic test_branch();
      idle_inputs();
      tick();                                   // 300C -> 3010
      pc_sel = 3'b001; br_imm = 16'hFFFC; br_taken = 1;
      tick();
      tests_run++;
      if (pc !== 32'h3004) begin tests_failed++; $display("FAIL br_taken got %h want 3004", pc); end
      idle_inputs();
      repeat (3) tick();                        // back to 3010
      pc_sel = 3'b001; br_imm = 16'hFFFC; br_taken = 0;
      tick();
      tests_run++;
      if (pc !== 32'h3014) begin tests_failed++; $display("FAIL br_not_taken got %h want 3014", pc); end
   endtask

   task automatic test_jal_ret();
      idle_inputs();
      rst = 1; tick(); rst = 0;
      pc_sel = 3'b011; j_index = 26'h0000100;
      tick();
      tests_run++;
      if (pc !== 32'h0000_0400) begin tests_failed++; $display("FAIL jal_pc got %h want 00000400", pc); end
      tests_run++;
      if (ras_count !== 3'd1) begin tests_failed++; $display("FAIL jal_count got %0d want 1", ras_count); end
      pc_sel = 3'b101; jr_target = 32'h3100;
      tick();
      tests_run++;
      if (pc !== 32'h3004) begin tests_failed++; $display("FAIL ret_pc got %h want 3004", pc); end
      tests_run++;
      if (ras_count !== 3'd0) begin tests_failed++; $display("FAIL ret_count got %0d want 0", ras_count); end
      tick();
      tests_run++;
      if (pc !== 32'h3100) begin tests_failed++; $display("FAIL ret_empty got %h want 3100", pc); end
   endtask

   task automatic test_overflow();
      logic [31:0] pushed [5];
      idle_inputs();
      pc_sel = 3'b011;
      for (int i = 0; i < 5; i++) begin
         pushed[i] = pc + 32'd4;
         j_index   = 26'(32'h200 + i * 32'h10);
         tick();
         tests_run++;
         if (ras_ovf !== (i == 4)) begin tests_failed++; $display("FAIL ovf_push%0d got %b want %b", i, ras_ovf, (i == 4)); end
      end
      tests_run++;
      if (ras_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count got %0d want 4", ras_count); end
      pc_sel = 3'b101; jr_target = 32'hDEAD_0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (pc !== pushed[4-i]) begin tests_failed++; $display("FAIL ovf_ret%0d got %h want %h", i, pc, pushed[4-i]); end
         tests_run++;
         if (ras_ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear%0d got %b want 0", i, ras_ovf); end
      end
      tests_run++;
      if (ras_count !== 3'd0) begin tests_failed++; $display("FAIL ovf_drain got %0d want 0", ras_count); end
   endtask

   task automatic test_stall_exc();
      logic [31:0] held;
      idle_inputs();
      pc_sel = 3'b011; j_index = 26'h40;
      tick();                                   // one entry on the RAS
      held = pc;
      stall = 1; pc_sel = 3'b011;
      tick();
      tests_run++;
      if (pc !== held) begin tests_failed++; $display("FAIL stall_pc got %h want %h", pc, held); end
      tests_run++;
      if (ras_count !== 3'd1) begin tests_failed++; $display("FAIL stall_count got %0d want 1", ras_count); end
      exc_req = 1; stall = 1;
      tick();
      tests_run++;
      if (pc !== 32'h4180) begin tests_failed++; $display("FAIL exc_pc got %h want 4180", pc); end
      tests_run++;
      if (ras_count !== 3'd1) begin tests_failed++; $display("FAIL exc_count got %0d want 1", ras_count); end
      idle_inputs();
      eret = 1; epc = 32'h3020; pc_sel = 3'b101;
      tick();
      tests_run++;
      if (pc !== 32'h3020) begin tests_failed++; $display("FAIL eret_pc got %h want 3020", pc); end
      tests_run++;
      if (ras_count !== 3'd1) begin tests_failed++; $display("FAIL eret_count got %0d want 1", ras_count); end
      idle_inputs();
      rst = 1; stall = 1; exc_req = 1;
      tick();
      tests_run++;
      if (pc !== 32'h3000) begin tests_failed++; $display("FAIL rst_stall got %h want 3000", pc); end
      tests_run++;
      if (ras_count !== 3'd0) begin tests_failed++; $display("FAIL rst_stall_count got %0d want 0", ras_count); end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 59) == 0);
         exc_req   = ($urandom_range(0, 29) == 0);
         eret      = ($urandom_range(0, 24) == 0);
         stall     = ($urandom_range(0, 3) == 0);
         pc_sel    = 3'($urandom_range(0, 7));
         br_imm    = 16'($urandom);
         br_taken  = 1'($urandom);
         j_index   = 26'($urandom);
         jr_target = $urandom;
         epc       = $urandom;
         tick();
         tests_run++;
         if (pc !== m_pc) begin tests_failed++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, m_pc); end
         tests_run++;
         if (pc_plus4 !== m_pc + 32'd4) begin tests_failed++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, pc_plus4, m_pc + 32'd4); end
         tests_run++;
         if (ras_count !== 3'(ras_q.size())) begin tests_failed++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, ras_count, ras_q.size()); end
         tests_run++;
         if (ras_ovf !== m_ovf) begin tests_failed++; $display("FAIL rnd_ovf[%0d] got %b want %b", i, ras_ovf, m_ovf); end
         tests_run++;
         if (pc_misalign !== (m_pc[1:0] != 2'b00)) begin tests_failed++; $display("FAIL rnd_misalign[%0d] got %b want %b", i, pc_misalign, (m_pc[1:0] != 2'b00)); end
      end
   endtask

   initial begin
      m_pc  = 32'h0;
      m_ovf = 1'b0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_seq();
      test_branch();
      test_jal_ret();
      test_overflow();
      test_stall_exc();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
